// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU engine.
//   - op codes presented on in_op
//   - 1-bit slice output select encodings
//   - FSM state encoding
//   - helpers mapping an op code to slice controls
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SUB and SLT invert B and start with carry 1 (two's complement subtract).
  function automatic logic op_binvert(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Reserved codes run through the AND path; their result is forced to 0 at the end.
  function automatic logic [1:0] op_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_OR:                  sel = SEL_OR;
      OP_ADD, OP_SUB, OP_SLT: sel = SEL_SUM;
      default:                sel = SEL_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: combinational 1-bit ALU slice.
// Ports:
//   a_i, b_i    operand bits
//   cin_i       carry in
//   binvert_i   invert b before use
//   less_i      value routed out when sel_i == SEL_LESS
//   sel_i       output select (AND / OR / SUM / LESS)
//   out_o       selected result bit
//   cout_o      full-adder carry out
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       binvert_i,
  input  logic       less_i,
  input  logic [1:0] sel_i,
  output logic       out_o,
  output logic       cout_o
);

  logic b_eff;
  logic sum;

  assign b_eff  = b_i ^ binvert_i;
  assign sum    = a_i ^ b_eff ^ cin_i;
  assign cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);

  always_comb begin
    out_o = 1'b0;
    case (sel_i)
      SEL_AND:  out_o = a_i & b_eff;
      SEL_OR:   out_o = a_i | b_eff;
      SEL_SUM:  out_o = sum;
      SEL_LESS: out_o = less_i;
      default:  out_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_engine.sv
// alu_serial_engine: bit-serial ALU sequencer.
// Operands are accepted over in_valid/in_ready, evaluated LSB-first one bit per
// clock through a single alu_serial_slice, and the result is offered over
// out_valid/out_ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand handshake
//   in_a, in_b [WIDTH]         operands
//   in_op [3]                  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   out_valid/out_ready        result handshake
//   out_result [WIDTH]         result
//   out_zero, out_cout, out_ovf  result flags
// Build option: define ALU_SERIAL_OVF_EN to compute signed overflow and to use
// the overflow-corrected sign for SLT; otherwise out_ovf is tied 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for operands
// ST_RUN  | one operand bit per clock, WIDTH clocks
// ST_DONE | result registered; out_valid follows one clock later and
//         | holds until out_ready
module alu_serial_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_out;
  logic             slice_cout;
  logic             last_bit;
  logic             ovf_raw;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cout;
  logic             fin_ovf;

  alu_serial_slice u_slice (
    .a_i       (a_q[0]),
    .b_i       (b_q[0]),
    .cin_i     (carry_q),
    .binvert_i (op_binvert(op_q)),
    .less_i    (1'b0),
    .sel_i     (op_sel(op_q)),
    .out_o     (slice_out),
    .cout_o    (slice_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // Result as it will look after this cycle's shift; on the last bit it is complete.
  assign sum_full = {slice_out, res_q[WIDTH-1:1]};

  // On the last bit carry_q is the carry into the MSB and slice_cout the carry out.
`ifdef ALU_SERIAL_OVF_EN
  assign ovf_raw = carry_q ^ slice_cout;
`else
  assign ovf_raw = 1'b0;
`endif

  always_comb begin
    fin_res  = '0;
    fin_cout = 1'b0;
    fin_ovf  = 1'b0;
    case (op_q)
      OP_AND, OP_OR: begin
        fin_res = sum_full;
      end
      OP_ADD, OP_SUB: begin
        fin_res  = sum_full;
        fin_cout = slice_cout;
        fin_ovf  = ovf_raw;
      end
      OP_SLT: begin
        // sign of a-b, corrected by overflow when that is available
        fin_res  = {{(WIDTH-1){1'b0}}, slice_out ^ ovf_raw};
        fin_cout = slice_cout;
      end
      default: begin
        fin_res = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          cnt_d   = '0;
          carry_d = op_binvert(in_op);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = sum_full;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          res_d   = fin_res;
          zero_d  = (fin_res == '0);
          cout_d  = fin_cout;
          ovf_d   = fin_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_AND;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_serial_engine.sv
// Testbench for alu_serial_engine: one WIDTH=8 and one WIDTH=32 instance,
// directed and random operations compared against an arithmetic reference model.
module tb_alu_serial_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, z8, c8, o8;
  logic [7:0] a8, b8, r8;
  logic [2:0] op8;

  logic        iv32, ir32, ov32, or32, z32, c32, o32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  op32;

  int checks = 0;
  int errors = 0;

  alu_serial_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_op(op8),
    .out_valid(ov8), .out_ready(or8), .out_result(r8),
    .out_zero(z8), .out_cout(c8), .out_ovf(o8)
  );

  alu_serial_engine #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_op(op32),
    .out_valid(ov32), .out_ready(or32), .out_result(r32),
    .out_zero(z32), .out_cout(c32), .out_ovf(o32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular / signed integer arithmetic on w-bit values.
  task automatic model(input int w, input logic [2:0] op, input logic [31:0] ai, input logic [31:0] bi,
                       output logic [31:0] r, output logic z, output logic c, output logic o);
    longint m, a, b, s, sa, sb, hi, lo;
    m  = (longint'(1) << w) - 1;
    a  = longint'(ai) & m;
    b  = longint'(bi) & m;
    sa = (((a >> (w-1)) & 1) != 0) ? a - (m + 1) : a;
    sb = (((b >> (w-1)) & 1) != 0) ? b - (m + 1) : b;
    hi = (m + 1) / 2 - 1;
    lo = -((m + 1) / 2);
    s  = 0;
    r  = '0; c = 1'b0; o = 1'b0;
    case (op)
      3'b000: r = 32'(a & b);
      3'b001: r = 32'(a | b);
      3'b010: begin
        s = a + b;
        r = 32'(s & m);
        c = ((s >> w) & 1) != 0;
`ifdef ALU_SERIAL_OVF_EN
        o = (sa + sb > hi) || (sa + sb < lo);
`endif
      end
      3'b110: begin
        s = a + ((~b) & m) + 1;
        r = 32'(s & m);
        c = ((s >> w) & 1) != 0;
`ifdef ALU_SERIAL_OVF_EN
        o = (sa - sb > hi) || (sa - sb < lo);
`endif
      end
      3'b111: begin
        s = a + ((~b) & m) + 1;
        c = ((s >> w) & 1) != 0;
`ifdef ALU_SERIAL_OVF_EN
        r = (sa < sb) ? 32'd1 : 32'd0;
`else
        r = 32'((s >> (w-1)) & 1);
`endif
      end
      default: r = '0;
    endcase
    z = (r == 32'd0);
  endtask

  task automatic drive(input bit big, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    if (big) begin
      iv32 = v; op32 = op; a32 = a; b32 = b; or32 = ordy;
    end else begin
      iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; or8 = ordy;
    end
  endtask

  task automatic peek(input bit big, output logic ov, output logic ir, output logic [31:0] r,
                      output logic z, output logic c, output logic o);
    if (big) begin
      ov = ov32; ir = ir32; r = r32; z = z32; c = c32; o = o32;
    end else begin
      ov = ov8; ir = ir8; r = {24'h0, r8}; z = z8; c = c8; o = o8;
    end
  endtask

  task automatic do_op(input bit big, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int w, cyc;
    logic [31:0] er, r;
    logic ez, ec, eo, ov, ir, z, c, o;
    w = big ? 32 : 8;
    model(w, op, a, b, er, ez, ec, eo);
    drive(big, 1'b1, op, a, b, 1'b0);
    peek(big, ov, ir, r, z, c, o);
    check("in_ready_idle", 64'(ir), 64'd1);
    @(posedge clk); #1;
    // operands change while running; the engine must ignore them
    drive(big, 1'b1, 3'($urandom), $urandom, $urandom, 1'b0);
    cyc = 0;
    peek(big, ov, ir, r, z, c, o);
    while (!ov && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      peek(big, ov, ir, r, z, c, o);
    end
    check("latency", 64'(cyc), 64'(w + 1));
    check("result", 64'(r), 64'(er));
    check("zero", 64'(z), 64'(ez));
    check("cout", 64'(c), 64'(ec));
    check("ovf", 64'(o), 64'(eo));
    check("in_ready_busy", 64'(ir), 64'd0);
    for (int h = 0; h < hold; h++) begin
      drive(big, 1'b1, 3'($urandom), $urandom, $urandom, 1'b0);
      @(posedge clk); #1;
      peek(big, ov, ir, r, z, c, o);
      check("hold_valid", 64'(ov), 64'd1);
      check("hold_stable", {60'(r), z, c, o, ir}, {60'(er), ez, ec, eo, 1'b0});
    end
    drive(big, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    drive(big, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    peek(big, ov, ir, r, z, c, o);
    check("post_handshake", {62'(0), ov, ir}, 64'd1);
  endtask

  initial begin
    logic ov, ir, z, c, o;
    logic [31:0] r;
    int seen;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    peek(1'b0, ov, ir, r, z, c, o);
    check("rst_state", {58'(0), ir, ov, r[7:0] != 8'd0, z, c, o}, {58'(0), 6'b100000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 3'b010, 32'h7F, 32'h01, 0);
    do_op(1'b0, 3'b110, 32'h05, 32'h05, 0);
    do_op(1'b0, 3'b000, 32'hF0, 32'h3C, 0);
    do_op(1'b0, 3'b001, 32'hF0, 32'h0F, 0);
    do_op(1'b0, 3'b111, 32'h80, 32'h01, 0);
    do_op(1'b0, 3'b111, 32'h7F, 32'h80, 0);
    do_op(1'b0, 3'b010, 32'hC3, 32'h5A, 5);

    // reset while the engine is on bit 3
    drive(1'b0, 1'b1, 3'b010, 32'h12, 32'h34, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    peek(1'b0, ov, ir, r, z, c, o);
    check("abort_state", {62'(0), ir, ov}, 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    do_op(1'b0, 3'b010, 32'h01, 32'h01, 0);

    do_op(1'b1, 3'b010, 32'hFFFFFFFF, 32'h1, 0);
    do_op(1'b1, 3'b011, 32'hDEADBEEF, 32'h12345678, 0);

    for (int i = 0; i < 24; i++)
      do_op(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    for (int i = 0; i < 8; i++)
      do_op(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
